// File: rtl/tone_pkg.sv
// tone_pkg: note codes, reference half-periods and decoder FSM encoding,
// shared by the tone generator and the tone decoder.
package tone_pkg;
    typedef logic [3:0] note_t;

    localparam note_t NOTE_NONE = 4'd0;
    localparam note_t NOTE_L5   = 4'd1;
    localparam note_t NOTE_L6   = 4'd2;
    localparam note_t NOTE_M1   = 4'd3;
    localparam note_t NOTE_M2   = 4'd4;
    localparam note_t NOTE_M3   = 4'd5;
    localparam note_t NOTE_M5   = 4'd6;
    localparam note_t NOTE_M6   = 4'd7;
    localparam note_t NOTE_H1   = 4'd8;

    // Half-period in 48 MHz cycles (generator divider end count + 1), indexed by note code
    localparam logic [8:1][15:0] REF_HP = {
        16'd22957, 16'd27274, 16'd30613, 16'd36403,
        16'd40866, 16'd45864, 16'd54546, 16'd61225
    };

    localparam logic [1:0] ST_SILENT = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    function automatic logic near(input logic [15:0] x, input logic [15:0] r, input int sh);
        logic [15:0] d;
        d = x >= r ? x - r : r - x;
        return d <= (r >> sh);
    endfunction
endpackage

// File: rtl/tone_decoder_if.sv
// tone_decoder_if: decoded note result bus from the tone decoder to its consumer.
interface tone_decoder_if;
    import tone_pkg::*;
    note_t       note_code;
    logic        note_valid;
    logic        note_strobe;
    logic [15:0] half_period;

    modport master (output note_code, note_valid, note_strobe, half_period);
    modport slave  (input  note_code, note_valid, note_strobe, half_period);
endinterface

// File: rtl/tone_match.sv
// tone_match: combinational classifier of a measured half-period against the note table.
module tone_match
    import tone_pkg::*;
#(
    parameter int TOL_SHIFT = 6
) (
    input  logic [15:0] interval,
    output note_t       code
);
    logic [8:1] hit;

    for (genvar i = 1; i <= 8; i++) begin : g_hit
        assign hit[i] = near(interval, REF_HP[i], TOL_SHIFT);
    end

    assign code = hit[1] ? NOTE_L5 :
                  hit[2] ? NOTE_L6 :
                  hit[3] ? NOTE_M1 :
                  hit[4] ? NOTE_M2 :
                  hit[5] ? NOTE_M3 :
                  hit[6] ? NOTE_M5 :
                  hit[7] ? NOTE_M6 :
                  hit[8] ? NOTE_H1 : NOTE_NONE;
endmodule

// File: rtl/tone_decoder.sv
// tone_decoder: measures edge-to-edge distance of beep_in and locks onto a note
// after two consecutive matching intervals.
module tone_decoder
    import tone_pkg::*;
#(
    parameter int CLK_HZ    = 48000000,
    parameter int TOL_SHIFT = 6
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    input  logic           beep_in,
    tone_decoder_if.master bus
);
    logic        s1, s2, s3;
    logic        edge_p, sat;
    logic [15:0] cnt;
    logic [1:0]  state;
    note_t       cand, code;
    logic        unused_clk_hz;

    assign unused_clk_hz = ^CLK_HZ;
    assign edge_p = s2 ^ s3;
    assign sat    = cnt == 16'hFFFF;

    tone_match #(.TOL_SHIFT(TOL_SHIFT)) u_match (.interval(cnt), .code(code));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) {s3, s2, s1} <= 3'b000;
        else         {s3, s2, s1} <= {s2, s1, beep_in};
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt             <= 16'd0;
            bus.half_period <= 16'd0;
        end else begin
            cnt <= edge_p ? 16'd1 : sat ? cnt : cnt + 16'd1;
            if (edge_p) bus.half_period <= cnt;
        end
    end

    // Edges are handled before saturation so a final interval of 65535 still classifies
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state           <= ST_SILENT;
            cand            <= NOTE_NONE;
            bus.note_code   <= NOTE_NONE;
            bus.note_valid  <= 1'b0;
            bus.note_strobe <= 1'b0;
        end else begin
            bus.note_strobe <= 1'b0;
            if (edge_p) begin
                case (state)
                    ST_SILENT: state <= ST_ARMED;
                    ST_ARMED: if (code != NOTE_NONE) begin
                        state <= ST_CHECK;
                        cand  <= code;
                    end
                    ST_CHECK: if (code == cand) begin
                        state           <= ST_LOCKED;
                        bus.note_code   <= cand;
                        bus.note_valid  <= 1'b1;
                        bus.note_strobe <= 1'b1;
                    end else if (code != NOTE_NONE) begin
                        cand <= code;
                    end else begin
                        state <= ST_ARMED;
                    end
                    default: if (code != bus.note_code) begin
                        bus.note_valid <= 1'b0;
                        bus.note_code  <= NOTE_NONE;
                        state          <= code != NOTE_NONE ? ST_CHECK : ST_ARMED;
                        cand           <= code;
                    end
                endcase
            end else if (sat && state != ST_SILENT) begin
                state          <= ST_SILENT;
                bus.note_valid <= 1'b0;
                bus.note_code  <= NOTE_NONE;
            end
        end
    end
endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: classifier vector table plus directed lock/unlock/timeout/reset sequences.
module tb_tone_decoder;
    import tone_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        beep_in = 1'b0;
    logic [15:0] m_iv = 16'd0;
    note_t       m_code;
    int          ncmp = 0;
    int          nerr = 0;
    int          nstb = 0;

    typedef struct {
        logic [15:0] iv;
        note_t       code;
    } vec_t;
    vec_t tbl[18];

    tone_decoder_if bus();

    tone_decoder #(.CLK_HZ(48000000), .TOL_SHIFT(6)) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .beep_in(beep_in),
        .bus(bus)
    );

    tone_match #(.TOL_SHIFT(6)) u_ref (.interval(m_iv), .code(m_code));

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) if (bus.note_strobe) nstb++;

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic outs_zero(input string name);
        chk({name, "_code"}, bus.note_code, 0);
        chk({name, "_valid"}, bus.note_valid, 0);
        chk({name, "_strobe"}, bus.note_strobe, 0);
        chk({name, "_hp"}, bus.half_period, 0);
    endtask

    // Toggle, check state 3 cycles later (edge pulse + registered update), then fill to n cycles
    task automatic edge_chk(input int n, input int v, input int c, input int hp);
        beep_in = ~beep_in;
        cyc(3);
        chk("edge_valid", bus.note_valid, v);
        chk("edge_code", bus.note_code, c);
        chk("edge_hp", bus.half_period, hp);
        cyc(n - 3);
    endtask

    task automatic lock_edge(input int n, input int c, input int hp, input int strobes);
        beep_in = ~beep_in;
        cyc(2);
        chk("lock_early_valid", bus.note_valid, 0);
        cyc(1);
        chk("lock_valid", bus.note_valid, 1);
        chk("lock_code", bus.note_code, c);
        chk("lock_strobe", bus.note_strobe, 1);
        chk("lock_hp", bus.half_period, hp);
        cyc(1);
        chk("lock_strobe_low", bus.note_strobe, 0);
        chk("lock_strobe_count", nstb, strobes);
        cyc(n - 4);
    endtask

    initial begin
        int a;
        int nx;
        tbl = '{
            '{16'd0,     NOTE_NONE}, '{16'd45864, NOTE_M1},   '{16'd46580, NOTE_M1},
            '{16'd46581, NOTE_NONE}, '{16'd45148, NOTE_M1},   '{16'd45147, NOTE_NONE},
            '{16'd61225, NOTE_L5},   '{16'd54546, NOTE_L6},   '{16'd40866, NOTE_M2},
            '{16'd36403, NOTE_M3},   '{16'd30613, NOTE_M5},   '{16'd27274, NOTE_M6},
            '{16'd22957, NOTE_H1},   '{16'd23315, NOTE_H1},   '{16'd23316, NOTE_NONE},
            '{16'd65535, NOTE_NONE}, '{16'd62181, NOTE_L5},   '{16'd62182, NOTE_NONE}
        };
        cyc(3);
        outs_zero("reset");
        sys_rst = 1'b0;
        cyc(2);
        foreach (tbl[i]) begin
            m_iv = tbl[i].iv;
            #1;
            chk($sformatf("match_%0d", tbl[i].iv), m_code, tbl[i].code);
        end
        cyc(1);

        // M_1 lock on third edge, then timeout after the tone stops
        beep_in = ~beep_in;
        cyc(45864);
        edge_chk(45864, 0, 0, 45864);
        lock_edge(65537, NOTE_M1, 45864, 1);
        chk("timeout_before_valid", bus.note_valid, 1);
        cyc(1);
        chk("timeout_valid", bus.note_valid, 0);
        chk("timeout_code", bus.note_code, 0);

        // Tolerance edge: +716 locks, +717 unlocks and stays armed
        beep_in = ~beep_in;
        cyc(46580);
        edge_chk(46580, 0, 0, 46580);
        lock_edge(46581, NOTE_M1, 46580, 2);
        edge_chk(46581, 0, 0, 46581);
        edge_chk(22957, 0, 0, 46581);

        // H_1 lock, then switch to M_6
        edge_chk(22957, 0, 0, 22957);
        lock_edge(27274, NOTE_H1, 22957, 3);
        edge_chk(27274, 0, 0, 27274);
        lock_edge(61225, NOTE_M6, 27274, 4);

        // Alternating L_5 / L_6 never locks
        a = 61225;
        for (int i = 0; i < 4; i++) begin
            nx = (a == 61225) ? 54546 : 61225;
            edge_chk(nx, 0, 0, a);
            a = nx;
        end
        chk("alt_strobe_count", nstb, 4);

        // Lock on L_5, reset mid-lock, relock needs a fresh first edge
        edge_chk(61225, 0, 0, 61225);
        lock_edge(10, NOTE_L5, 61225, 5);
        #1;
        sys_rst = 1'b1;
        beep_in = 1'b0;
        #1;
        outs_zero("async_rst");
        cyc(2);
        sys_rst = 1'b0;
        cyc(5);
        outs_zero("post_rst");
        beep_in = ~beep_in;
        cyc(61225);
        edge_chk(61225, 0, 0, 61225);
        lock_edge(10, NOTE_L5, 61225, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
